// File: rtl/rib_pkg.sv
// Shared types and encodings for the RIB-to-AXI4-Lite data bridge.
package rib_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWaddr = 3'd1,
        StWresp = 3'd2,
        StRaddr = 3'd3,
        StRdata = 3'd4,
        StDone  = 3'd5
    } rib_state_e;

    localparam logic [1:0] RIB_SZ_B = 2'b00;
    localparam logic [1:0] RIB_SZ_H = 2'b01;
    localparam logic [1:0] RIB_SZ_W = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/rib_lane_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
module rib_lane_align
    import rib_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misalign_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        is_unsigned;

    assign shifted     = rdata_i >> {lane_i, 3'b000};
    assign is_unsigned = size_i[2];

    always_comb begin
        wdata_o    = wdata_i;
        wstrb_o    = 4'hF;
        misalign_o = 1'b0;
        rdata_o    = rdata_i;
        case (size_i[1:0])
            RIB_SZ_B: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = 4'b0001 << lane_i;
                rdata_o = is_unsigned ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            RIB_SZ_H: begin
                wdata_o    = {2{wdata_i[15:0]}};
                wstrb_o    = 4'b0011 << lane_i;
                misalign_o = lane_i[0];
                rdata_o    = is_unsigned ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            // Word and the reserved encoding behave identically.
            default: misalign_o = (lane_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/rib_axil_bridge.sv
// Converts the core's single-cycle RAM-port request into one AXI4-Lite transaction,
// stalling the core through hold_o until the transaction completes.
module rib_axil_bridge
    import rib_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_we_i,
    input  logic              req_re_i,
    input  logic [2:0]        req_size_i,
    output logic [31:0]       rdata_o,
    output logic              hold_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    rib_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [2:0]        size_q, size_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              err_q, err_d;

    logic              req;
    logic              idle;
    logic [2:0]        al_size;
    logic [1:0]        al_lane;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic [3:0]        al_wstrb;
    logic              al_misalign;

    assign req  = req_we_i | req_re_i;
    assign idle = (state_q == StIdle);

    // One aligner serves both paths: the live request while idle, the latched one afterwards.
    assign al_size = idle ? req_size_i : size_q;
    assign al_lane = idle ? req_addr_i[1:0] : addr_q[1:0];

    rib_lane_align u_lane_align (
        .size_i     (al_size),
        .lane_i     (al_lane),
        .wdata_i    (req_wdata_i),
        .rdata_i    (m_rdata),
        .wdata_o    (al_wdata),
        .wstrb_o    (al_wstrb),
        .misalign_o (al_misalign),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d    = req_addr_i;
                    wdata_d   = al_wdata;
                    wstrb_d   = al_wstrb;
                    size_d    = req_size_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (al_misalign) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        if (!req_we_i) begin
                            rdata_d = '0;
                        end
                    end else if (req_we_i) begin
                        state_d   = StWaddr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRaddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWaddr: begin
                aw_done_d = aw_done_q | (awvalid_q & m_awready);
                w_done_d  = w_done_q | (wvalid_q & m_wready);
                awvalid_d = awvalid_q & ~m_awready;
                wvalid_d  = wvalid_q & ~m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d  = StWresp;
                    bready_d = 1'b1;
                end
            end
            StWresp: begin
                if (m_bvalid) begin
                    state_d  = StDone;
                    bready_d = 1'b0;
                    err_d    = (m_bresp != AXI_RESP_OKAY);
                end
            end
            StRaddr: begin
                if (m_arready) begin
                    state_d   = StRdata;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdata: begin
                if (m_rvalid) begin
                    state_d  = StDone;
                    rready_d = 1'b0;
                    if (m_rresp == AXI_RESP_OKAY) begin
                        rdata_d = al_rdata;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
        end
    end

    // Stall is released in DONE so the core advances exactly once per access.
    always_comb begin
        hold_o = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle:                             hold_o = req;
                StWaddr, StWresp, StRaddr, StRdata: hold_o = 1'b1;
                default:                            hold_o = 1'b0;
            endcase
        end
    end

    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign m_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_rib_axil_bridge.sv
// Scoreboarded bench: a negedge-driven AXI4-Lite slave model with programmable latencies.
module tb_rib_axil_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_re;
    logic [2:0]  req_size;
    logic [31:0] rdata_o;
    logic        hold_o;
    logic        err_o;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    rib_axil_bridge #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_we_i    (req_we),
        .req_re_i    (req_re),
        .req_size_i  (req_size),
        .rdata_o     (rdata_o),
        .hold_o      (hold_o),
        .err_o       (err_o),
        .m_awaddr    (m_awaddr),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_araddr    (m_araddr),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic        r_stall  = 1'b0;
    logic [31:0] sl_rdata = '0;
    logic [1:0]  sl_rresp = 2'b00;
    logic [1:0]  sl_bresp = 2'b00;
    int          aw_cnt = 0;
    int          w_cnt  = 0;
    int          ar_vcycles = 0;
    logic [31:0] cap_awaddr = '0;
    logic [31:0] cap_wdata  = '0;
    logic [3:0]  cap_wstrb  = '0;
    logic [31:0] cap_araddr = '0;

    initial begin
        int   aw_wait = 0;
        int   w_wait  = 0;
        logic aw_seen = 1'b0;
        logic w_seen  = 1'b0;
        logic b_pend  = 1'b0;
        logic r_pend  = 1'b0;
        logic b_fire  = 1'b0;
        logic r_fire  = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (b_fire) begin m_bvalid = 1'b0; b_fire = 1'b0; end
            if (r_fire) begin m_rvalid = 1'b0; r_fire = 1'b0; end
            if (rst) begin
                m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
                m_bvalid = 1'b0; m_rvalid = 1'b0;
                aw_wait = 0; w_wait = 0;
                aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
                continue;
            end
            if (b_pend) begin m_bvalid = 1'b1; m_bresp = sl_bresp; b_pend = 1'b0; end
            if (r_pend && !r_stall) begin
                m_rvalid = 1'b1; m_rdata = sl_rdata; m_rresp = sl_rresp; r_pend = 1'b0;
            end
            if (m_awvalid) begin m_awready = (aw_wait >= aw_delay); aw_wait++; end
            else begin m_awready = 1'b0; aw_wait = 0; end
            if (m_wvalid) begin m_wready = (w_wait >= w_delay); w_wait++; end
            else begin m_wready = 1'b0; w_wait = 0; end
            m_arready = m_arvalid;
            if (m_arvalid) ar_vcycles++;
            // A valid/ready pair seen here completes on the coming posedge.
            if (m_awvalid && m_awready) begin aw_cnt++; cap_awaddr = m_awaddr; aw_seen = 1'b1; end
            if (m_wvalid && m_wready) begin
                w_cnt++; cap_wdata = m_wdata; cap_wstrb = m_wstrb; w_seen = 1'b1;
            end
            if (aw_seen && w_seen) begin b_pend = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end
            if (m_arvalid && m_arready) begin cap_araddr = m_araddr; r_pend = 1'b1; end
            if (m_bvalid && m_bready) b_fire = 1'b1;
            if (m_rvalid && m_rready) r_fire = 1'b1;
        end
    end

    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];
    int          exp_hold_q[$];
    logic        last_c1_ar;

    task automatic run_req(input string tag, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_hold);
        int n;
        exp_rd_q.push_back(exp_rd);
        exp_err_q.push_back(exp_err);
        exp_hold_q.push_back(exp_hold);
        @(negedge clk);
        req_we = we; req_re = re; req_addr = addr; req_wdata = wd; req_size = sz;
        #1;
        n = 0;
        last_c1_ar = 1'b0;
        while (hold_o && n < 100) begin
            n++;
            @(negedge clk);
            req_we = 1'b0; req_re = 1'b0;
            #1;
            if (n == 1) last_c1_ar = m_arvalid;
        end
        check_val({tag, "_done"}, 32'(n < 100), 32'd1);
        check_val({tag, "_hold"}, n, exp_hold_q.pop_front());
        check_val({tag, "_rdata"}, rdata_o, exp_rd_q.pop_front());
        check_val({tag, "_err"}, 32'(err_o), 32'(exp_err_q.pop_front()));
        @(negedge clk);
        #1;
        check_val({tag, "_err_pulse"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0;
        int n;
        rst = 1'b1;
        req_we = 1'b0; req_re = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_outputs", {rdata_o[15:0], 6'b0, hold_o, err_o, m_awvalid, m_wvalid,
                                  m_bready, m_arvalid, m_rready, m_wstrb}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Word load, zero-wait slave
        sl_rdata = 32'hDEADBEEF;
        run_req("ld_word", 1'b0, 1'b1, 32'h100, '0, 3'b010, 32'hDEADBEEF, 1'b0, 3);
        check_val("ld_word_c1_arvalid", 32'(last_c1_ar), 32'd1);
        check_val("ld_word_araddr", cap_araddr, 32'h100);

        sl_rdata = 32'h80FFFFFF;
        run_req("ld_byte_s", 1'b0, 1'b1, 32'h103, '0, 3'b000, 32'hFFFFFF80, 1'b0, 3);
        run_req("ld_byte_u", 1'b0, 1'b1, 32'h103, '0, 3'b100, 32'h00000080, 1'b0, 3);
        check_val("ld_byte_araddr", cap_araddr, 32'h100);
        sl_rdata = 32'h80010000;
        run_req("ld_half_s", 1'b0, 1'b1, 32'h102, '0, 3'b001, 32'hFFFF8001, 1'b0, 3);

        // Half store with skewed channel readiness, both orders
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 3 : 0;
            w_delay  = (k == 0) ? 0 : 3;
            aw_cnt = 0; w_cnt = 0;
            run_req(k == 0 ? "st_half_awlate" : "st_half_wlate", 1'b1, 1'b0, 32'h202,
                    32'h1234ABCD, 3'b001, 32'hFFFF8001, 1'b0, 6);
            check_val("st_half_awaddr", cap_awaddr, 32'h200);
            check_val("st_half_wdata", cap_wdata, 32'hABCDABCD);
            check_val("st_half_wstrb", 32'(cap_wstrb), 32'hC);
            check_val("st_half_aw_cnt", aw_cnt, 1);
            check_val("st_half_w_cnt", w_cnt, 1);
        end
        aw_delay = 0; w_delay = 0;

        run_req("st_byte", 1'b1, 1'b0, 32'h301, 32'h000000A5, 3'b000, 32'hFFFF8001, 1'b0, 3);
        check_val("st_byte_wdata", cap_wdata, 32'hA5A5A5A5);
        check_val("st_byte_wstrb", 32'(cap_wstrb), 32'h2);

        // Misaligned word load: no bus cycle
        ar0 = ar_vcycles;
        run_req("ld_misalign", 1'b0, 1'b1, 32'h101, '0, 3'b010, 32'h0, 1'b1, 1);
        check_val("ld_misalign_no_ar", ar_vcycles - ar0, 0);

        sl_rdata = 32'hCAFEF00D;
        run_req("ld_word2", 1'b0, 1'b1, 32'h108, '0, 3'b010, 32'hCAFEF00D, 1'b0, 3);
        sl_rdata = 32'h12345678; sl_rresp = 2'b10;
        run_req("ld_rresp_err", 1'b0, 1'b1, 32'h104, '0, 3'b010, 32'h0, 1'b1, 3);
        sl_rresp = 2'b00;
        sl_bresp = 2'b11;
        run_req("st_bresp_err", 1'b1, 1'b0, 32'h10C, 32'h0BADF00D, 3'b010, 32'h0, 1'b1, 3);
        sl_bresp = 2'b00;

        // Reset while waiting in RDATA
        sl_rdata = 32'hCAFEF00D;
        run_req("ld_pre_rst", 1'b0, 1'b1, 32'h108, '0, 3'b010, 32'hCAFEF00D, 1'b0, 3);
        r_stall = 1'b1;
        @(negedge clk);
        req_re = 1'b1; req_addr = 32'h400; req_size = 3'b010;
        n = 0;
        #1;
        while (!m_rready && n < 20) begin
            @(negedge clk);
            req_re = 1'b0;
            #1;
            n++;
        end
        req_re = 1'b0;
        check_val("rst_reach_rdata", 32'(m_rready), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_rready", 32'(m_rready), 32'd0);
        check_val("rst_async_hold", 32'(hold_o), 32'd0);
        check_val("rst_async_rdata", rdata_o, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        r_stall = 1'b0;
        sl_rdata = 32'h11223344;
        run_req("ld_post_rst", 1'b0, 1'b1, 32'h400, '0, 3'b010, 32'h11223344, 1'b0, 3);

        // Simultaneous we/re: the write wins
        ar0 = ar_vcycles;
        aw_cnt = 0; w_cnt = 0;
        run_req("st_we_re", 1'b1, 1'b1, 32'h500, 32'h55AA55AA, 3'b010, 32'h11223344, 1'b0, 3);
        check_val("st_we_re_aw_cnt", aw_cnt, 1);
        check_val("st_we_re_no_ar", ar_vcycles - ar0, 0);
        check_val("st_we_re_awaddr", cap_awaddr, 32'h500);
        check_val("st_we_re_wdata", cap_wdata, 32'h55AA55AA);
        check_val("st_we_re_wstrb", 32'(cap_wstrb), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rib_axil_bridge.md
# rib_axil_bridge

Data-side bus bridge that sits directly downstream of the CPU core's RAM port and converts its single-cycle request (addr/wdata/we/re/size) into AXI4-Lite master transactions. While a transaction is outstanding it stalls the pipeline through the core's `hold_flag_i`. It also performs byte-lane steering, write-strobe generation and load sign/zero extension, so the core always sees a right-aligned 32-bit result.

## Interface
- `ADDR_W`, default 32: address width on both the core side and the AXI side; the data width is fixed at 32.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_addr_i` in ADDR_W: byte address from the core.
- `req_wdata_i` in 32: store data from the core, right-aligned.
- `req_we_i` in 1: store request.
- `req_re_i` in 1: load request.
- `req_size_i` in 3: access size. `[1:0]` 00=byte, 01=half, 10=word, 11=reserved (treated as word). `[2]`=1 means unsigned load.
- `rdata_o` out 32: load result, extended to 32 bits, registered.
- `hold_o` out 1: stall request to the core.
- `err_o` out 1: one-cycle pulse on a misaligned access or a non-OKAY response.
- `m_awaddr` out ADDR_W, `m_awvalid` out 1, `m_awready` in 1: AXI write address channel.
- `m_wdata` out 32, `m_wstrb` out 4, `m_wvalid` out 1, `m_wready` in 1: AXI write data channel.
- `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1: AXI write response channel.
- `m_araddr` out ADDR_W, `m_arvalid` out 1, `m_arready` in 1: AXI read address channel.
- `m_rdata` in 32, `m_rresp` in 2, `m_rvalid` in 1, `m_rready` out 1: AXI read data channel.

## Operation
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- **IDLE, request accepted:** a request is `req_we_i | req_re_i`. If both are asserted, the write wins. On acceptance, latch the address, the steered data, the strobe, the size and the lane (`addr[1:0]`). `hold_o` goes high combinationally in that same cycle. Next state is WADDR for a write, RADDR for a read.
- **Alignment:** a half-word access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, is misaligned. A misaligned access issues no bus cycle, goes straight to DONE, pulses `err_o`, and loads 0 into `rdata_o` for a load.
- **WADDR:** drive `m_awvalid` and `m_wvalid` together.
  - Each valid drops independently on its own handshake; per-channel "done" flags track this.
  - Leave for WRESP once both handshakes have occurred, in the same or different cycles.
  - `m_awaddr` is word-aligned (`addr & ~3`).
- **WRESP:** drive `m_bready`=1. On `m_bvalid`, go to DONE; if `m_bresp!=00`, pulse `err_o`.
- **RADDR:** drive `m_arvalid` until `m_arready`, then go to RDATA.
- **RDATA:** drive `m_rready`=1. On `m_rvalid`, capture the extended `m_rdata` into `rdata_o`, or 0 if `m_rresp!=00` (which also pulses `err_o`). Then go to DONE.
- **DONE:** `hold_o`=0 for exactly one cycle, the cycle in which the core advances. Requests are ignored in this cycle. Always return to IDLE.
- **Write steering:**
  - byte: `wdata={4{d[7:0]}}`, `wstrb=1<<lane`.
  - half: `wdata={2{d[15:0]}}`, `wstrb=3<<lane`.
  - word: `wstrb=4'hF`.
- **Read extension:**
  - Select the byte/half at the lane.
  - Sign-extend when `size[2]=0`, zero-extend otherwise.
  - Word loads pass through unchanged.
- **`rdata_o` hold:** holds its value until the next completed load; stores do not modify it.

## Timing
- **Reset values:** all outputs 0, state IDLE. This is asynchronous: an assertion mid-transaction drops every valid/ready immediately. Any partial AXI handshake is abandoned, and the interconnect is reset together with the bridge.
- **Hold, combinational:** IDLE with a request, or any of WADDR/WRESP/RADDR/RDATA.
- **Hold, low:** IDLE with no request, and DONE.
- **Valids:** registered; the first valid appears in the cycle after acceptance.
- **Minimum read with ready/valid returned immediately:**
  - c0 accept, c1 `m_arvalid`, c2 `m_rvalid`, c3 DONE with `rdata_o` valid.
  - Hold is high c0–c2, so a load stalls the core 3 cycles.
- **Minimum write:** c0 accept, c1 aw/w handshake, c2 `m_bvalid`, c3 DONE.
- **Misaligned access:** c0 accept, c1 DONE with `err_o` high; 1 stall cycle.
- **Valid stability:** valids stay asserted with stable payload until their ready; there is no combinational path from any ready to any valid.
- **Back-to-back:** a new request is accepted in the IDLE cycle that follows DONE.

## Structure
- **Package `rib_pkg`:**
  - state enum `rib_state_e`.
  - size encodings `RIB_SZ_B/H/W`.
  - `AXI_RESP_OKAY=2'b00`.
- **Sub-module `rib_lane_align`:** purely combinational. It takes size, lane and data, and produces `wdata`, `wstrb`, the misalign flag, and the extended read data. It is shared by the write and read paths.
- **Top:** FSM, request latches, aw/w done flags and the `rdata_o` register.

## Test plan
- **Word load:** `re=1`, addr `0x100`, size `010`, slave `rdata=0xDEADBEEF`, zero wait → `arvalid` in c1, `hold_o` high for 3 cycles, `rdata_o=0xDEADBEEF` at DONE, `err_o=0`.
- **Byte loads at addr `0x103`, slave `rdata=0x80FFFFFF`:**
  - size `000` → `0xFFFFFF80`.
  - size `100` → `0x00000080`.
- **Half store:** `we=1`, addr `0x202`, `wdata=0x1234ABCD` → `awaddr=0x200`, `wdata=0xABCDABCD`, `wstrb=4'b1100`. Run twice: once with `awready` delayed 3 cycles after `wready`, once with the reverse. Each channel must handshake exactly once.
- **Misaligned word load** at `0x101` → no `arvalid` ever, `err_o` pulses 1 cycle, `rdata_o=0`, hold lasts 1 cycle.
- **Error response:** `m_rresp=2'b10` → `rdata_o=0` and `err_o` pulse. `m_bresp=2'b11` on a store → `err_o` pulse. In both cases the core is released normally.
- **Reset mid-transaction:** assert `rst` during RDATA with `m_rvalid` low → `m_rready`/`hold_o` drop asynchronously. After release, the state is IDLE and a new load completes correctly. `req_we_i` and `req_re_i` asserted together → a write is issued.
